fp_arith_pipe: RTL and testbench

//  Pipelined IEEE-754 single-precision arithmetic pair: a multiplier (fixed
//  5-cycle latency) and an adder/subtractor (fixed 7-cycle latency) that share
//  one clock, enable and reset. Used by the LPC/alpha calculators as the

---
 rtl/fp_arith_pipe.sv | 160 ++++++++++++++++
 tb/tb_fp_arith_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fp_arith_pipe.sv
// IEEE-754 single-precision multiplier (5-cycle) and adder/subtractor (7-cycle)
// sharing one clock, enable and synchronous reset. Denormals are treated as
// signed zero on input and flushed to signed zero on output; rounding is
// round-to-nearest, ties-to-even.
module fp_arith_pipe (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic [31:0] iMulA,
  input  logic [31:0] iMulB,
  output logic [31:0] oMulResult,
  output logic        oMulNan,
  input  logic        iAddSub,
  input  logic [31:0] iAddA,
  input  logic [31:0] iAddB,
  output logic [31:0] oAddResult
);
  localparam int MULT_LATENCY = 5;
  localparam int ADD_LATENCY  = 7;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Rounds a 25-bit {carry,hidden,frac} mantissa result and packs it; handles
  // the post-rounding carry plus overflow to infinity and underflow flush.
  function automatic logic [31:0] f_pack(input logic s, input logic signed [9:0] e_in,
                                         input logic [24:0] m_in, input logic up);
    logic [24:0]       mr;
    logic [22:0]       fr;
    logic signed [9:0] e;
    e  = e_in;
    mr = m_in + {24'd0, up};
    fr = mr[24] ? mr[23:1] : mr[22:0];
    if (mr[24]) e = e + 10'sd1;
    if (e >= 10'sd255)    f_pack = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0) f_pack = {s, 31'd0};
    else                  f_pack = {s, e[7:0], fr};
  endfunction

  // Returns {nan_flag, product}.
  function automatic logic [32:0] f_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s, za, zb, ia, ib, na, nb, g, st;
    logic [47:0]       p;
    logic [23:0]       m;
    logic signed [9:0] e;
    s  = a[31] ^ b[31];
    za = (a[30:23] == 8'd0);
    zb = (b[30:23] == 8'd0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    if (na || nb || (za && ib) || (ia && zb)) f_mul = {1'b1, QNAN};
    else if (ia || ib)                        f_mul = {1'b0, s, 8'hFF, 23'd0};
    else if (za || zb)                        f_mul = {1'b0, s, 31'd0};
    else f_mul = {1'b0, f_pack(s, e, {1'b0, m}, g & (st | m[0]))};
  endfunction

  function automatic logic [4:0] f_lzc(input logic [27:0] v);
    logic found;
    f_lzc = 5'd0;
    found = 1'b0;
    for (int i = 27; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      f_lzc = f_lzc + 5'd1;
      end
    end
  endfunction

  // Mantissas are 28 bits: carry, hidden, 23 fraction, guard, round, sticky.
  function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b_in,
                                        input logic add);
    logic [31:0]       b, bl, bs;
    logic              za, zb, ia, ib, na, nb;
    logic [7:0]        d;
    logic [27:0]       ml, ms, sh, mask, sum, nm;
    logic [4:0]        lz;
    logic signed [9:0] e;
    b  = {b_in[31] ^ ~add, b_in[30:0]};
    za = (a[30:23] == 8'd0);
    zb = (b[30:23] == 8'd0);
    ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a[30:0] < b[30:0]) begin bl = b; bs = a; end
    else                   begin bl = a; bs = b; end
    d  = bl[30:23] - bs[30:23];
    ml = {2'b01, bl[22:0], 3'b000};
    ms = {2'b01, bs[22:0], 3'b000};
    mask = 28'd0;
    if (d >= 8'd28) begin
      sh = 28'd1;
    end else begin
      mask = (28'd1 << d[4:0]) - 28'd1;
      sh   = (ms >> d[4:0]) | {27'd0, |(ms & mask)};
    end
    sum = (bl[31] == bs[31]) ? ml + sh : ml - sh;
    e   = $signed({2'b00, bl[30:23]});
    lz  = f_lzc(sum);
    if (sum[27]) begin
      nm = {1'b0, sum[27:1]} | {27'd0, sum[0]};
      e  = e + 10'sd1;
    end else begin
      nm = sum << (lz - 5'd1);
      e  = e - $signed({5'd0, lz}) + 10'sd1;
    end
    if (na || nb || (ia && ib && (a[31] != b[31]))) f_add = QNAN;
    else if (ia)            f_add = {a[31], 8'hFF, 23'd0};
    else if (ib)            f_add = {b[31], 8'hFF, 23'd0};
    else if (za && zb)      f_add = {a[31] & b[31], 31'd0};
    else if (za)            f_add = b;
    else if (zb)            f_add = a;
    else if (sum == 28'd0)  f_add = 32'd0;
    else f_add = f_pack(bl[31], e, nm[27:3], nm[2] & ((|nm[1:0]) | nm[3]));
  endfunction

  logic [31:0] r_mul_a, r_mul_b, r_add_a, r_add_b;
  logic        r_add_sub;
  logic [32:0] r_mul_pipe [2:MULT_LATENCY];
  logic [31:0] r_add_pipe [2:ADD_LATENCY];

  // Operand capture, compute stage and delay stages; everything freezes when disabled.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_mul_a   <= 32'd0;
      r_mul_b   <= 32'd0;
      r_add_a   <= 32'd0;
      r_add_b   <= 32'd0;
      r_add_sub <= 1'b0;
      for (int i = 2; i <= MULT_LATENCY; i++) r_mul_pipe[i] <= 33'd0;
      for (int i = 2; i <= ADD_LATENCY; i++)  r_add_pipe[i] <= 32'd0;
    end else if (iEnable) begin
      r_mul_a   <= iMulA;
      r_mul_b   <= iMulB;
      r_add_a   <= iAddA;
      r_add_b   <= iAddB;
      r_add_sub <= iAddSub;
      r_mul_pipe[2] <= f_mul(r_mul_a, r_mul_b);
      r_add_pipe[2] <= f_add(r_add_a, r_add_b, r_add_sub);
      for (int i = 3; i <= MULT_LATENCY; i++) r_mul_pipe[i] <= r_mul_pipe[i-1];
      for (int i = 3; i <= ADD_LATENCY; i++)  r_add_pipe[i] <= r_add_pipe[i-1];
    end
  end

  assign oMulResult = r_mul_pipe[MULT_LATENCY][31:0];
  assign oMulNan    = r_mul_pipe[MULT_LATENCY][32];
  assign oAddResult = r_add_pipe[ADD_LATENCY];
endmodule

// File: tb/tb_fp_arith_pipe.sv
// Scoreboard bench for fp_arith_pipe: expected results are queued with the
// enabled-edge index at which they must appear; between results the outputs
// must hold the last expected value.
module tb_fp_arith_pipe;
  logic        iClock = 1'b0;
  logic        iReset, iEnable, iAddSub, oMulNan;
  logic [31:0] iMulA, iMulB, iAddA, iAddB, oMulResult, oAddResult;

  fp_arith_pipe dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable),
    .iMulA(iMulA), .iMulB(iMulB), .oMulResult(oMulResult), .oMulNan(oMulNan),
    .iAddSub(iAddSub), .iAddA(iAddA), .iAddB(iAddB), .oAddResult(oAddResult)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic        nan;
    string       tag;
  } sb_t;

  sb_t         q_mul[$];
  sb_t         q_add[$];
  int          n_edge = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] last_mul = 32'd0;
  logic [31:0] last_add = 32'd0;
  logic        last_nan = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // value n * 2^e2 for positive n
  function automatic logic [31:0] fp_of(input int n, input int e2);
    int          p;
    logic [31:0] m;
    p = 0;
    for (int i = 0; i < 31; i++) if (n[i]) p = i;
    m = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p + e2), m[22:0]};
  endfunction

  task automatic tick();
    logic  en, rst;
    sb_t   e;
    string mtag, atag;
    en = iEnable;
    rst = iReset;
    mtag = "stall_hold_mul";
    atag = "stall_hold_add";
    @(posedge iClock);
    #1;
    if (rst) begin
      q_mul.delete();
      q_add.delete();
      last_mul = 32'd0;
      last_add = 32'd0;
      last_nan = 1'b0;
      mtag = "reset_mul";
      atag = "reset_add";
    end else if (en) begin
      n_edge++;
      mtag = "hold_mul";
      atag = "hold_add";
      if (q_mul.size() > 0 && q_mul[0].due == n_edge) begin
        e = q_mul.pop_front();
        last_mul = e.res;
        last_nan = e.nan;
        mtag = e.tag;
      end
      if (q_add.size() > 0 && q_add[0].due == n_edge) begin
        e = q_add.pop_front();
        last_add = e.res;
        atag = e.tag;
      end
    end
    check_val(mtag, oMulResult, last_mul);
    check_val({mtag, "_nan"}, {31'd0, oMulNan}, {31'd0, last_nan});
    check_val(atag, oAddResult, last_add);
  endtask

  task automatic send(input string tag,
                      input logic [31:0] ma, input logic [31:0] mb,
                      input logic [31:0] mexp, input logic mnan,
                      input logic as, input logic [31:0] aa, input logic [31:0] ab,
                      input logic [31:0] aexp);
    iMulA = ma;
    iMulB = mb;
    iAddSub = as;
    iAddA = aa;
    iAddB = ab;
    iEnable = 1'b1;
    q_mul.push_back('{due: n_edge + 5, res: mexp, nan: mnan, tag: {tag, "_mul"}});
    q_add.push_back('{due: n_edge + 7, res: aexp, nan: 1'b0, tag: {tag, "_add"}});
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      send("idle", 32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "time limit");
  end

  initial begin
    iReset = 1'b1; iEnable = 1'b0; iAddSub = 1'b0;
    iMulA = 32'd0; iMulB = 32'd0; iAddA = 32'd0; iAddB = 32'd0;
    tick();
    tick();
    iReset = 1'b0;

    send("t1",  32'h3F800000, 32'h40000000, 32'h40000000, 1'b0, 1'b1, 32'h3FC00000, 32'h40100000, 32'h40700000);
    send("t2",  32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0, 32'h3F800000, 32'h3F800000, 32'h00000000);
    send("t3",  32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b0, 1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    send("t4",  32'hBF800000, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 32'h80000000, 32'h80000000);
    send("t5",  32'h7FA00000, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 32'h7F800000, 32'h7F800000, 32'h7FC00000);
    send("t6",  32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b1, 32'h3F800000, 32'h33800000, 32'h3F800000);
    send("t7",  32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b1, 32'h3F800001, 32'h33800000, 32'h3F800002);
    send("t8",  32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    send("t9",  32'hC0400000, 32'h40000000, 32'hC0C00000, 1'b0, 1'b1, 32'h7F800000, 32'hC0000000, 32'h7F800000);
    send("t10", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0, 32'h3F800000, 32'h40400000, 32'hC0000000);
    send("t11", 32'h3F000000, 32'h3F000000, 32'h3E800000, 1'b0, 1'b0, 32'h00000000, 32'hBF800000, 32'h3F800000);
    send("t12", 32'hFF800000, 32'hBF800000, 32'h7F800000, 1'b0, 1'b0, 32'h3F800001, 32'h3F800000, 32'h34000000);
    idle(8);

    for (int k = 1; k <= 12; k++) begin
      if (k == 7) begin
        iEnable = 1'b0;
        for (int s = 0; s < 3; s++) begin
          iMulA = $urandom; iMulB = $urandom; iAddA = $urandom; iAddB = $urandom;
          iAddSub = 1'($urandom);
          tick();
        end
      end
      send($sformatf("s%0d", k), fp_of(k, 0), 32'h3F000000, fp_of(k, -1), 1'b0,
           1'(k % 2 == 0), fp_of(k, 0), 32'h3F000000,
           (k % 2 == 0) ? fp_of(2 * k + 1, -1) : fp_of(2 * k - 1, -1));
    end
    iEnable = 1'b0;
    for (int s = 0; s < 3; s++) tick();
    idle(8);

    for (int k = 20; k < 24; k++)
      send($sformatf("pre%0d", k), fp_of(k, 0), 32'h40000000, fp_of(k, 1), 1'b0,
           1'b1, fp_of(k, 0), 32'h3F800000, fp_of(k + 1, 0));
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    for (int k = 3; k < 6; k++)
      send($sformatf("post%0d", k), fp_of(k, 0), 32'h40000000, fp_of(k, 1), 1'b0,
           1'b0, fp_of(k, 0), 32'h3F800000, fp_of(k - 1, 0));
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
